bp_update_sched: RTL

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_update_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: queues resolved EX branches and ID JAL installs,
// and sweeps the predictor table with clear writes. Optional BP_STATS_EN adds branch/mispredict counters.
`timescale 1ns/1ps
module bp_update_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        id_jal_valid,
    input  logic [31:0] id_jal_pc,
    input  logic [31:0] id_jal_target,
    output logic        id_jal_ready,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        stall,
`ifdef BP_STATS_EN
    output logic [31:0] br_count,
    output logic [31:0] mispred_count,
`endif
    output logic        state_dbg
);

    // Handshake: an ID JAL transfers on any cycle where id_jal_valid and id_jal_ready are both
    // high at the clock edge; the EX branch has no ready and is simply dropped when the FIFO is full.

    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;

    logic [31:0] fifo_pc     [4];
    logic        fifo_taken  [4];
    logic [31:0] fifo_target [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;

    logic        ex_br, ex_push, id_push, push, pop;
    logic [31:0] push_pc, push_target;
    logic        push_taken;

    assign ex_br       = ex_valid & ex_is_br;
    assign ex_push     = ex_br & (count < 3'd4);
    assign id_push     = id_jal_valid & id_jal_ready;
    assign push        = ex_push | id_push;
    assign pop         = (state_q == RUN) && (count != 3'd0);

    assign push_pc     = ex_push ? ex_pc     : id_jal_pc;
    assign push_taken  = ex_push ? ex_taken  : 1'b1;
    assign push_target = ex_push ? ex_target : id_jal_target;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= push_pc;
            fifo_taken[wr_ptr]  <= push_taken;
            fifo_target[wr_ptr] <= push_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = 8'd0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd255) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Clear sweep has priority on the update port; queued entries wait until it finishes.
    always_comb begin
        upd_valid  = 1'b0;
        upd_pc     = 32'd0;
        upd_taken  = 1'b0;
        upd_target = 32'd0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                upd_valid = 1'b1;
                upd_pc    = {1'b1, 21'd0, idx_q, 2'b00};
            end else if (count != 3'd0) begin
                upd_valid  = 1'b1;
                upd_pc     = fifo_pc[rd_ptr];
                upd_taken  = fifo_taken[rd_ptr];
                upd_target = fifo_target[rd_ptr];
            end
        end
    end

    assign id_jal_ready = !rst && (count < 3'd4) && !ex_push;
    assign stall        = !rst && (count >= 3'd3);
    assign clear_busy   = !rst && (state_q == CLEAR);
    assign mispredict   = !rst && ex_br &&
                          ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc  = rst ? 32'd0 : (ex_taken ? ex_target : ex_pc + 32'd4);
    assign state_dbg    = state_q;

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (ex_br)      br_count      <= br_count + 32'd1;
            if (mispredict) mispred_count <= mispred_count + 32'd1;
        end
    end
`endif

endmodule
